// File: rtl/alu_if.sv
// alu_if: operand/function inputs and registered result/flag outputs of the ALU.
//   master: drives A, B, F; observes W, c, z (and v when ALU_OVERFLOW_EN is defined)
//   slave : the ALU side of the same signals
interface alu_if;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] F;
    logic [7:0] W;
    logic       c;
    logic       z;
`ifdef ALU_OVERFLOW_EN
    logic       v;
    modport master (output A, B, F, input W, c, z, v);
    modport slave  (input A, B, F, output W, c, z, v);
`else
    modport master (output A, B, F, input W, c, z);
    modport slave  (input A, B, F, output W, c, z);
`endif
endinterface

// File: rtl/alu.sv
// alu: 8-bit registered ALU, 8 ops selected by F, result and flags valid 1 cycle after inputs.
//   clk    rising-edge clock
//   rst    synchronous active-high reset (W=00, c=0, z=1, v=0)
//   bus.A  operand A, bus.B operand B, bus.F function select
//   bus.W  registered result, bus.c carry/borrow/shift-out, bus.z zero flag
//   bus.v  signed overflow, present only when ALU_OVERFLOW_EN is defined
module alu (
    input logic clk,
    input logic rst,
    alu_if.slave bus
);
    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] w_next;
    logic       c_next;
    assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
    // diff[8] is the borrow, i.e. A < B unsigned; shared by SUB and SLT
    assign diff = {1'b0, bus.A} - {1'b0, bus.B};
    always_comb begin
        w_next = sum[7:0];
        c_next = sum[8];
        case (bus.F)
            3'b000: {c_next, w_next} = sum;
            3'b001: {c_next, w_next} = diff;
            3'b010: {c_next, w_next} = {1'b0, bus.A & bus.B};
            3'b011: {c_next, w_next} = {1'b0, bus.A | bus.B};
            3'b100: {c_next, w_next} = {1'b0, bus.A ^ bus.B};
            3'b101: {c_next, w_next} = {bus.A, 1'b0};
            3'b110: {w_next, c_next} = {1'b0, bus.A};
            3'b111: {c_next, w_next} = {1'b0, 7'b0, diff[8]};
        endcase
    end
`ifdef ALU_OVERFLOW_EN
    logic v_next;
    assign v_next = (bus.F == 3'b000) ? (bus.A[7] == bus.B[7]) && (w_next[7] != bus.A[7]) :
                    (bus.F == 3'b001) ? (bus.A[7] != bus.B[7]) && (w_next[7] != bus.A[7]) : 1'b0;
    always_ff @(posedge clk) bus.v <= rst ? 1'b0 : v_next;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.W <= 8'h00;
            bus.c <= 1'b0;
            bus.z <= 1'b1;
        end else begin
            bus.W <= w_next;
            bus.c <= c_next;
            bus.z <= (w_next == 8'h00);
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors for alu, checked against an arithmetic model every cycle plus literal expectations.
module tb_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [10:0] exp_r = '0;
    logic        exp_ok = 1'b0;
    logic [10:0] got;

    alu_if bus ();
    alu dut (.clk(clk), .rst(rst), .bus(bus));

    always #50 clk = ~clk;

    // returns {v, z, c, W} from plain integer arithmetic
    function automatic logic [10:0] model(input int a, input int b, input int f);
        int r, cc, sa, sb, sr;
        logic [7:0] w;
        logic vv;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        vv = 1'b0;
        cc = 0;
        case (f)
            0: begin r = a + b; cc = (r > 255) ? 1 : 0; sr = sa + sb; vv = (sr > 127) || (sr < -128); end
            1: begin r = a - b; cc = (a < b) ? 1 : 0; sr = sa - sb; vv = (sr > 127) || (sr < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a * 2; cc = (a >= 128) ? 1 : 0; end
            6: begin r = a / 2; cc = a % 2; end
            default: r = (a < b) ? 1 : 0;
        endcase
        w = 8'(r & 255);
        return {vv, w == 8'h00, cc[0], w};
    endfunction

`ifdef ALU_OVERFLOW_EN
    assign got = {bus.v, bus.z, bus.c, bus.W};
`else
    assign got = {1'b0, bus.z, bus.c, bus.W};
`endif

    always @(posedge clk) begin
        exp_r  <= rst ? 11'h200 : model(bus.A, bus.B, bus.F);
        exp_ok <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_ok) begin
            total++;
`ifdef ALU_OVERFLOW_EN
            if (got !== exp_r) begin
`else
            if (got[9:0] !== exp_r[9:0]) begin
`endif
                bad++;
                $display("FAIL model t=%0t got={v,z,c,W}=%h exp=%h", $time, got, exp_r);
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        @(negedge clk);
        rst   = r;
        bus.A = a;
        bus.B = b;
        bus.F = f;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input logic [7:0] w, input logic cc, input logic zz);
        total++;
        if (bus.W !== w || bus.c !== cc || bus.z !== zz) begin
            bad++;
            $display("FAIL %s got W=%h c=%b z=%b exp W=%h c=%b z=%b", n, bus.W, bus.c, bus.z, w, cc, zz);
        end
    endtask

    task automatic pin(input string n, input logic [10:0] g, input logic [10:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s model got=%h exp=%h", n, g, e);
        end
    endtask

    logic [7:0] sweep_w [8] = '{8'h29, 8'h23, 8'h02, 8'h27, 8'h25, 8'h4C, 8'h13, 8'h00};

    initial begin
        bus.A = 8'hFF;
        bus.B = 8'hFF;
        bus.F = 3'b000;
        pin("m_sub_ovf", model(8'h7F, 8'hFF, 1), 11'h580);
        pin("m_shl",     model(8'h26, 8'h03, 5), 11'h04C);
        pin("m_add_wrap", model(8'hFF, 8'h01, 0), 11'h300);
        pin("m_shr",     model(8'h81, 8'h00, 6), 11'h140);
        step(1'b1, 8'hFF, 8'hFF, 3'b000); lit("reset", 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'hFF, 8'hFF, 3'b000); lit("rel_add", 8'hFE, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h26, 8'h03, 3'(i));
            lit($sformatf("sweep_f%0d", i), sweep_w[i], 1'b0, i == 7);
        end
        step(1'b0, 8'hFF, 8'h01, 3'b000); lit("add_wrap", 8'h00, 1'b1, 1'b1);
`ifdef ALU_OVERFLOW_EN
        pin("add_wrap_v", {10'b0, bus.v}, 11'h000);
`endif
        step(1'b0, 8'h00, 8'h01, 3'b001); lit("sub_borrow", 8'hFF, 1'b1, 1'b0);
        step(1'b0, 8'h7F, 8'hFF, 3'b001); lit("sub_7f_ff", 8'h80, 1'b1, 1'b0);
`ifdef ALU_OVERFLOW_EN
        pin("sub_v", {10'b0, bus.v}, 11'h001);
`endif
        step(1'b0, 8'h81, 8'h00, 3'b101); lit("shl81", 8'h02, 1'b1, 1'b0);
        step(1'b0, 8'h81, 8'h00, 3'b110); lit("shr81", 8'h40, 1'b1, 1'b0);
        step(1'b0, 8'h03, 8'h05, 3'b111); lit("slt", 8'h01, 1'b0, 1'b0);
        step(1'b0, 8'h26, 8'h03, 3'b000); lit("lat_a", 8'h29, 1'b0, 1'b0);
        @(negedge clk);
        bus.F = 3'b001;
        #1;
        lit("lat_hold", 8'h29, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        lit("lat_b", 8'h23, 1'b0, 1'b0);
        step(1'b0, 8'h26, 8'h03, 3'b010); lit("mid_pre", 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h26, 8'h03, 3'b011); lit("mid_rst", 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h26, 8'h03, 3'b100); lit("post_rst", 8'h25, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++)
            step(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
